// File: rtl/extend_unit_12to32.sv
// Immediate extension unit: widens a 12-bit decoder immediate to a 32-bit operand
// in one of four modes, with a one-cycle registered output and a matching valid flag.
module extend_unit_12to32 #(
  parameter int          IN_W        = 12,
  parameter int          OUT_W       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       ext_mode,
  input  logic [IN_W-1:0]  Extender,
  output logic [OUT_W-1:0] Extendido,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_SHIFT1 = 2'b10,
    MODE_UPPER  = 2'b11
  } ext_mode_e;

  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] ext_q;
  logic             valid_q;

  // Every mode is fully defined, so the next value never depends on stale state.
  always_comb begin
    ext_d = {{20{Extender[11]}}, Extender};
    case (ext_mode_e'(ext_mode))
      MODE_SIGN:   ext_d = {{20{Extender[11]}}, Extender};
      MODE_ZERO:   ext_d = {20'b0, Extender};
      MODE_SHIFT1: ext_d = {{19{Extender[11]}}, Extender, 1'b0};
      MODE_UPPER:  ext_d = {Extender, 20'b0};
      default:     ext_d = {{20{Extender[11]}}, Extender};
    endcase
  end

  // The data register only loads on accepted inputs; idle cycles leave it holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q   <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      if (in_valid) begin
        ext_q <= ext_d;
      end
      valid_q <= in_valid;
    end
  end

  assign Extendido = ext_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_extend_unit_12to32.sv
// Scoreboard bench for extend_unit_12to32: directed vectors push expected results,
// and an independent monitor pops and compares whenever out_valid is seen.
module tb_extend_unit_12to32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  ext_mode;
  logic [11:0] Extender;
  logic [31:0] Extendido;
  logic        out_valid;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  extend_unit_12to32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ext_mode  (ext_mode),
    .Extender  (Extender),
    .Extendido (Extendido),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] mode, input logic [11:0] e, input logic [31:0] exp);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    ext_mode = mode;
    Extender = e;
    exp_q.push_back(exp);
    $display("issue mode=%b E=%h expect=%h", mode, e, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    Extender = 12'hABC;
  endtask

  // Monitor: compares every presented result against the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", Extendido, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("result", Extendido, e);
        $display("result got=%h expect=%h", Extendido, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    ext_mode = 2'b00;
    Extender = 12'hFFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_data", Extendido, 32'h0);
      chk("reset_valid", {31'b0, out_valid}, 32'h0);
    end

    // SIGN positive and boundary values
    drive(2'b00, 12'd0,   32'h0000_0000);
    drive(2'b00, 12'd100, 32'h0000_0064);
    drive(2'b00, 12'd250, 32'h0000_00FA);
    drive(2'b00, 12'd69,  32'h0000_0045);
    drive(2'b00, 12'h800, 32'hFFFF_F800);
    drive(2'b00, 12'hFFF, 32'hFFFF_FFFF);
    drive(2'b00, 12'h7FF, 32'h0000_07FF);
    // Other modes
    drive(2'b01, 12'hFFF, 32'h0000_0FFF);
    drive(2'b10, 12'hFFF, 32'hFFFF_FFFE);
    drive(2'b11, 12'hFFF, 32'hFFF0_0000);
    drive(2'b10, 12'h064, 32'h0000_00C8);
    drive(2'b10, 12'h7FF, 32'h0000_0FFE);
    drive(2'b11, 12'h123, 32'h1230_0000);
    idle();
    @(posedge clk); #1;
    chk("idle_valid", {31'b0, out_valid}, 32'h0);
    chk("idle_hold", Extendido, 32'h1230_0000);

    // Three back-to-back, then gap: data must hold the last value
    drive(2'b00, 12'h001, 32'h0000_0001);
    drive(2'b01, 12'h801, 32'h0000_0801);
    drive(2'b10, 12'h800, 32'hFFFF_F000);
    idle();
    @(posedge clk); #1;
    chk("gap_valid", {31'b0, out_valid}, 32'h0);
    chk("gap_hold", Extendido, 32'hFFFF_F000);
    @(posedge clk); #1;
    chk("gap_hold2", Extendido, 32'hFFFF_F000);

    // Reset in the same cycle as a valid input drops that input
    drive(2'b00, 12'h0AA, 32'h0000_00AA);
    drive(2'b01, 12'h0BB, 32'h0000_00BB);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    ext_mode = 2'b11;
    Extender = 12'h555;
    @(posedge clk); #1;
    chk("midrst_data", Extendido, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);

    // Recovery after reset release
    drive(2'b00, 12'hF00, 32'hFFFF_FF00);
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
